// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result readout path: default sizes, FSM
// state encoding, bank-select encoding and a bit-reverse helper.
package fft_pkg;

  localparam int FFT_N_LOG2   = 10;
  localparam int FFT_DATA_W   = 32;
  localparam int BITREV_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                     input int w);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      for (int j = 0; j < BITREV_MAX_W; j++) begin
        if ((i < w) && (i + j == w - 1)) r[i] = v[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reader_if.sv
// Bundle of the readout unit's control, bank-read and output-stream signals.
// master: the readout unit itself; slave: the surrounding system / banks / sink.
interface fft_out_reader_if
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DATA_W = FFT_DATA_W
);

  logic              start_i;
  logic              memsel_i;
  logic [N_LOG2-1:0] rd_addr_o;
  logic              rd_en_a_o;
  logic              rd_en_b_o;
  logic [DATA_W-1:0] rd_data_a_i;
  logic [DATA_W-1:0] rd_data_b_i;
  logic [DATA_W-1:0] out_data_o;
  logic [N_LOG2-1:0] out_index_o;
  logic              out_last_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              busy_o;
  logic              done_o;

  modport master (
    input  start_i, memsel_i, rd_data_a_i, rd_data_b_i, out_ready_i,
    output rd_addr_o, rd_en_a_o, rd_en_b_o, out_data_o, out_index_o,
           out_last_o, out_valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, memsel_i, rd_data_a_i, rd_data_b_i, out_ready_i,
    input  rd_addr_o, rd_en_a_o, rd_en_b_o, out_data_o, out_index_o,
           out_last_o, out_valid_o, busy_o, done_o
  );

endinterface

// File: rtl/fft_out_reader_out_fifo2.sv
// Two-entry synchronous FIFO holding {last, index, data} for the output stream.
// Storage is reset to zero so the exposed head word reads 0 while empty.
module out_fifo2 #(
  parameter int W = 43
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // Storage, pointers and occupancy; push and pop may occur in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/fft_out_reader.sv
// FFT result readout: drains the finished spectrum from the selected ping-pong
// bank in natural bin order and streams it over valid/ready.
// Build option: define BITREV_EN when the banks hold bit-reversed order; the
// read address is then the bit-reversed bin counter while out_index_o stays natural.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_i; bank select sampled on acceptance
// ST_READ  | issuing bank reads whenever the 2-entry buffer has credit
// ST_DRAIN | all reads issued; waiting for the buffer to empty, then done
module fft_out_reader
  import fft_pkg::*;
#(
  parameter int N_LOG2   = FFT_N_LOG2,
  parameter int DATA_W   = FFT_DATA_W,
  parameter int OUT_BINS = 512
) (
  input logic              clk,
  input logic              rst,
  fft_out_reader_if.master bus
);

  // One extra counter bit lets OUT_BINS = 2^N_LOG2 finish without wrapping.
  localparam int            CW       = N_LOG2 + 1;
  localparam int            EW       = 1 + N_LOG2 + DATA_W;
  localparam logic [CW-1:0] LAST_BIN = CW'(OUT_BINS - 1);

  rd_state_e         state;
  bank_e             bank;
  logic [CW-1:0]     cnt;
  logic              inflight;
  logic              inflight_last;
  logic [N_LOG2-1:0] inflight_idx;
  logic              busy_q;
  logic              done_q;

  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic [EW-1:0]     fifo_din;
  logic [EW-1:0]     fifo_dout;
  logic              pop;
  logic              issue;
  logic [2:0]        occ;
  logic [DATA_W-1:0] rd_data;

  // Credit: buffered + in-flight beats, less the one leaving this cycle, must stay below 2.
  assign pop   = bus.out_valid_o & bus.out_ready_i;
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state == ST_READ) && (occ < 3'd2);

  assign bus.rd_en_a_o = issue & (bank == BANK_A);
  assign bus.rd_en_b_o = issue & (bank == BANK_B);

`ifdef BITREV_EN
  logic [BITREV_MAX_W-1:0] addr_rev;
  assign addr_rev      = bitrev(BITREV_MAX_W'(cnt[N_LOG2-1:0]), N_LOG2);
  assign bus.rd_addr_o = addr_rev[N_LOG2-1:0];
`else
  assign bus.rd_addr_o = cnt[N_LOG2-1:0];
`endif

  // Bank data is valid the cycle after its enable, i.e. while inflight is set.
  assign rd_data   = (bank == BANK_B) ? bus.rd_data_b_i : bus.rd_data_a_i;
  assign fifo_din  = {inflight_last, inflight_idx, rd_data};
  assign fifo_push = inflight & (~fifo_full | pop);

  out_fifo2 #(.W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid_o = ~fifo_empty;
  assign {bus.out_last_o, bus.out_index_o, bus.out_data_o} = fifo_dout;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;

  // Sequencer: bin counter, in-flight tracking, busy/done and state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      bank          <= BANK_A;
      cnt           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_idx  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (issue) begin
        inflight_idx  <= cnt[N_LOG2-1:0];
        inflight_last <= (cnt == LAST_BIN);
        cnt           <= cnt + CW'(1);
      end
      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            bank   <= bank_e'(bus.memsel_i);
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue && (cnt == LAST_BIN)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_out_reader.md
# fft_out_reader

Result readout unit for the spectrum analyzer FFT core. When the FFT butterfly passes finish, this block reads the finished spectrum from the ping-pong bank that holds it, in natural bin order, and streams one complex bin per beat over a valid/ready interface to the magnitude/display path. It is the read-side counterpart of the address generation unit: that unit writes the banks, and this block drains them.

## Interface
Parameters:
- N_LOG2, 10: log2 of the FFT length. The memory address width equals N_LOG2.
- DATA_W, 32: width of a complex word, {re[15:0], im[15:0]}.
- OUT_BINS, 512: number of bins streamed, starting at bin 0. Legal range is 1..2^N_LOG2.

Ports:
- clk  in  1  single clock. All logic is on the rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- start_i  in  1  one-cycle pulse: a new spectrum is ready.
- memsel_i  in  1  bank holding the result (0 = A, 1 = B). Sampled on an accepted start_i.
- rd_addr_o  out  N_LOG2  read address, driven to both banks.
- rd_en_a_o / rd_en_b_o  out  1  read enable for bank A / bank B.
- rd_data_a_i / rd_data_b_i  in  DATA_W  bank read data. Valid 1 cycle after the enable.
- out_data_o  out  DATA_W  bin value.
- out_index_o  out  N_LOG2  bin number (natural order).
- out_last_o  out  1  asserted with bin OUT_BINS-1.
- out_valid_o  out  1  beat valid.
- out_ready_i  in  1  sink ready.
- busy_o  out  1  high from an accepted start until the last beat is transferred.
- done_o  out  1  one-cycle pulse after the last beat is transferred.

## Operation
- FSM states: IDLE, READ, DRAIN.
  - IDLE: start_i=1 latches memsel_i, clears the bin counter, and moves to READ.
  - READ: issues reads. After bin OUT_BINS-1 is issued, moves to DRAIN.
  - DRAIN: waits until the output buffer is empty, then pulses done_o and moves to IDLE.
- start_i while busy_o=1 is ignored. There is no restart and no error flag.
- Reads and the output buffer:
  - The block holds a 2-entry output buffer (FIFO) and an in-flight flag for the single read that is waiting on RAM latency.
  - A read is issued in a cycle when (count + inflight − pop) < 2, where pop = out_valid_o & out_ready_i. This keeps full throughput under continuous ready.
  - Only the enable of the latched bank is asserted. The other bank's enable stays 0.
- Returned data:
  - Data from the latched bank is pushed into the FIFO the cycle after the read.
  - out_index_o and out_last_o travel with the data through the FIFO.
- Handshake rules:
  - A transfer occurs when out_valid_o and out_ready_i are both high.
  - While out_valid_o=1 and out_ready_i=0, out_data_o, out_index_o and out_last_o hold stable.
  - out_valid_o never drops without a transfer.
- Width rules:
  - The bin counter is N_LOG2+1 bits wide, so OUT_BINS = 2^N_LOG2 terminates without wrapping.
  - rd_addr_o is derived from the counter's low N_LOG2 bits.
- Reset values: all outputs are 0, the FSM is in IDLE, the FIFO is empty, and in-flight is cleared.
- Reset mid-operation aborts the transfer immediately. No done_o is produced. After reset a fresh start_i is required.

## Timing
- Start to first beat:
  - start_i accepted at edge t.
  - First read enable during cycle t+1.
  - Data lands in the FIFO at edge t+2.
  - out_valid_o is high in cycle t+2.
- With out_ready_i held at 1: one beat per cycle, so OUT_BINS beats occupy cycles t+2 .. t+OUT_BINS+1.
- done_o pulses the cycle after the last transfer. busy_o falls in that same cycle.
- While out_ready_i is held at 0, at most 2 reads are outstanding (count + inflight ≤ 2). No read enable is asserted once that total reaches 2.

## Configuration
- BITREV_EN defined:
  - rd_addr_o = bit-reverse(bin counter), for banks written in bit-reversed order by the in-place DIT core.
  - out_index_o is still the natural bin number.
- BITREV_EN undefined: rd_addr_o = bin counter (the banks already hold natural order).

## Structure
- Shared package (fft_pkg): the N_LOG2 and DATA_W defaults, FSM state encoding, the bank-select encoding (BANK_A=0, BANK_B=1), and a bitrev function.
- Sub-module out_fifo2: a 2-entry synchronous FIFO carrying {last, index, data}, with count, push/pop, and full/empty outputs. The top-level module holds the FSM, counter, and credit logic.

## Test plan
- Basic stream:
  - Stimulus: bank A preloaded with word = address, memsel_i=0, start_i pulse, ready always 1, BITREV_EN undefined.
  - Response: 512 beats with data = index = 0..511, contiguous; last on index 511; done_o pulses once; bank B enable never asserted.
- Bit-reversed:
  - Stimulus: BITREV_EN defined, memsel_i=1.
  - Response: beat k shows rd_addr = bitrev10(k), e.g. k=1 → 512, k=2 → 256; out_index_o=k.
- Backpressure:
  - Stimulus: ready random at 30%, ready held at 0 for 20 cycles mid-stream.
  - Response: no beat lost or duplicated, output held stable while stalled, no more than 2 outstanding reads.
- Start while busy:
  - Stimulus: second start_i pulse at beat 100.
  - Response: ignored; exactly 512 beats and one done_o.
- Reset mid-stream:
  - Stimulus: rst asserted at beat 200, then a new start.
  - Response: outputs are 0 immediately; no done_o for the aborted run; the new run streams bins 0..511 cleanly.
- Full length:
  - Stimulus: OUT_BINS=1024.
  - Response: 1024 beats, last on index 1023, the counter does not wrap to 0.
